// File: rtl/uart_rx_buffer_if.sv
// Bundle of the core-side rx handshake and the CPU-side pop/status signals
// of the UART receive buffer.
interface uart_rx_buffer_if #(
  parameter int FIFO_ADDR_W = 4,
  parameter int DATA_W      = 8
);
  logic              core_rx_ready;
  logic [DATA_W-1:0] core_rx_data;
  logic              core_data_read_en;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              empty;
  logic              full;
  logic [FIFO_ADDR_W:0] level;
  logic              almost_full;
  logic              overrun;
  logic              overrun_clr;

  modport slave (
    input  core_rx_ready, core_rx_data, pop, overrun_clr,
    output core_data_read_en, pop_data, pop_valid, empty, full, level,
           almost_full, overrun
  );

  modport master (
    output core_rx_ready, core_rx_data, pop, overrun_clr,
    input  core_data_read_en, pop_data, pop_valid, empty, full, level,
           almost_full, overrun
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: drains the core's single-byte rx register into a FIFO
// and serves bytes to the CPU with level, almost-full and sticky overrun status.
module uart_rx_buffer #(
  parameter int FIFO_ADDR_W     = 4,
  parameter int DATA_W          = 8,
  parameter int ALMOST_FULL_LVL = 12
) (
  input logic             clk,
  input logic             rst,
  input logic             rst_soft,
  uart_rx_buffer_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] FULL_LVL = (FIFO_ADDR_W+1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] AF_LVL   = (FIFO_ADDR_W+1)'(ALMOST_FULL_LVL);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic                   srst;
  logic [1:0]             state_reg, state_next;
  logic [FIFO_ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_ADDR_W:0]   level_reg, level_next;
  logic [DATA_W-1:0]      pop_data_reg;
  logic                   pop_valid_reg;
  logic                   overrun_reg, overrun_next;
  logic                   in_read, full_now, pop_ok, wr_en, discard;

  logic [DATA_W-1:0] mem [DEPTH];

  assign srst = rst | rst_soft;

  // A pop accepted in the same cycle frees a slot, so a full FIFO still takes the byte.
  always_comb begin
    in_read  = (state_reg == READ) && !srst;
    full_now = (level_reg == FULL_LVL);
    pop_ok   = bus.pop && (level_reg != '0) && !srst;
    wr_en    = in_read && (!full_now || pop_ok);
    discard  = in_read && full_now && !pop_ok;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.core_rx_ready) state_next = READ;
      READ:    state_next = WAIT;
      WAIT:    if (!bus.core_rx_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    level_next = level_reg;
    if (wr_en && !pop_ok)
      level_next = level_reg + 1'b1;
    else if (!wr_en && pop_ok)
      level_next = level_reg - 1'b1;
  end

  // A discard in the same cycle as a clear leaves the flag set.
  always_comb begin
    overrun_next = overrun_reg;
    if (discard)
      overrun_next = 1'b1;
    else if (bus.overrun_clr)
      overrun_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      overrun_reg   <= overrun_next;
      pop_valid_reg <= pop_ok;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) begin
        pop_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= bus.core_rx_data;
  end

  assign bus.core_data_read_en = in_read;
  assign bus.pop_data          = pop_data_reg;
  assign bus.pop_valid         = pop_valid_reg;
  assign bus.level             = level_reg;
  assign bus.empty             = (level_reg == '0);
  assign bus.full              = full_now;
  assign bus.almost_full       = (level_reg >= AF_LVL);
  assign bus.overrun           = overrun_reg;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed plus randomized bench for uart_rx_buffer, checked against a
// queue-based model of the receive FIFO.
module tb_uart_rx_buffer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_soft = 1'b0;
  always #5 clk = ~clk;

  uart_rx_buffer_if #(.FIFO_ADDR_W(AW), .DATA_W(8)) bus ();

  uart_rx_buffer #(.FIFO_ADDR_W(AW), .DATA_W(8), .ALMOST_FULL_LVL(AF)) dut (
    .clk(clk), .rst(rst), .rst_soft(rst_soft), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit         ovr;
  logic [7:0] last_pop;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".level"}, 32'(bus.level), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(q.size() >= AF));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(ovr));
  endtask

  task automatic model_reset();
    q.delete();
    ovr = 1'b0;
    last_pop = 8'h00;
  endtask

  task automatic start_byte(input logic [7:0] b);
    bus.core_rx_ready = 1'b1;
    bus.core_rx_data  = b;
  endtask

  // Waits (bounded) until the strobe is visible; n = cycles it took.
  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    while (bus.core_data_read_en !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".strobe"}, 32'(bus.core_data_read_en), 32'd1);
  endtask

  // Called in the strobe cycle; optionally pops / clears overrun in that cycle.
  task automatic accept(input string tag, input logic [7:0] b, input bit do_pop,
                        input bit clr, input bit hold);
    bit pop_ok;
    bit disc;
    bus.pop = do_pop;
    bus.overrun_clr = clr;
    pop_ok = do_pop && (q.size() != 0);
    if (pop_ok) last_pop = q.pop_front();
    disc = (q.size() >= DEPTH);
    if (!disc) q.push_back(b);
    if (disc) ovr = 1'b1;
    else if (clr) ovr = 1'b0;
    tick();
    bus.pop = 1'b0;
    bus.overrun_clr = 1'b0;
    if (!hold) bus.core_rx_ready = 1'b0;
    chk({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(pop_ok));
    chk({tag, ".pop_data"}, 32'(bus.pop_data), 32'(last_pop));
    chk({tag, ".no_double_strobe"}, 32'(bus.core_data_read_en), 32'd0);
    check_status(tag);
    if (!hold) tick();
  endtask

  task automatic send(input string tag, input logic [7:0] b, input bit do_pop, input bit clr);
    int n;
    start_byte(b);
    wait_strobe(tag, n);
    chk({tag, ".latency"}, 32'(n), 32'd1);
    accept(tag, b, do_pop, clr, 1'b0);
  endtask

  task automatic pop_one(input string tag);
    bit ok;
    bus.pop = 1'b1;
    ok = (q.size() != 0);
    if (ok) last_pop = q.pop_front();
    tick();
    bus.pop = 1'b0;
    chk({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(ok));
    chk({tag, ".pop_data"}, 32'(bus.pop_data), 32'(last_pop));
    check_status(tag);
  endtask

  task automatic clear_ovr(input string tag);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    ovr = 1'b0;
    check_status(tag);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    bus.core_rx_ready = 1'b0;
    bus.core_rx_data  = 8'h00;
    bus.pop           = 1'b0;
    bus.overrun_clr   = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_status("reset");
    chk("reset.pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("reset.pop_data", 32'(bus.pop_data), 32'd0);
    chk("reset.strobe", 32'(bus.core_data_read_en), 32'd0);

    // Single byte round trip
    send("single", 8'hA5, 1'b0, 1'b0);
    pop_one("single_pop");
    chk("single_pop.value", 32'(bus.pop_data), 32'hA5);

    // Fill, wrap and ordering
    for (int i = 0; i < 16; i++) send("fill", 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop_one("wrap_pop");
    for (int i = 16; i < 20; i++) send("wrap_push", 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pop_one("drain");
      chk("drain.order", 32'(bus.pop_data), 32'(i + 4));
    end
    pop_one("drain_empty");

    // Overrun and simultaneous operations
    for (int i = 0; i < 16; i++) send("rfill", 8'($urandom), 1'b0, 1'b0);
    send("overrun", 8'h77, 1'b0, 1'b0);
    clear_ovr("ovr_clr");
    send("full_pop_write", 8'($urandom), 1'b1, 1'b0);
    send("clr_vs_discard", 8'($urandom), 1'b0, 1'b1);
    clear_ovr("ovr_clr2");
    while (q.size() != 0) pop_one("rdrain");
    send("empty_pop_write", 8'($urandom), 1'b1, 1'b0);
    pop_one("epw_pop");
    for (int i = 0; i < 3; i++) pop_one("pop_empty");

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: send("rand_send", 8'($urandom), 1'($urandom), 1'($urandom));
        2:    pop_one("rand_pop");
        default: clear_ovr("rand_clr");
      endcase
    end

    // Soft reset during WAIT with a byte still pending in the core
    while (q.size() != 0) pop_one("pre_soft");
    for (int i = 0; i < 4; i++) send("soft_fill", 8'($urandom), 1'b0, 1'b0);
    b = 8'($urandom);
    start_byte(b);
    wait_strobe("soft_wait", n);
    accept("soft_wait", b, 1'b0, 1'b0, 1'b1);
    rst_soft = 1'b1;
    tick();
    rst_soft = 1'b0;
    model_reset();
    check_status("soft_rst");
    chk("soft_rst.pop_data", 32'(bus.pop_data), 32'd0);
    wait_strobe("soft_reread", n);
    chk("soft_reread.latency", 32'(n), 32'd1);
    accept("soft_reread", b, 1'b0, 1'b0, 1'b0);
    pop_one("soft_pop");

    // Hard reset landing in READ: no strobe, byte re-read afterwards
    b = 8'($urandom);
    start_byte(b);
    wait_strobe("rst_read", n);
    rst = 1'b1;
    #1;
    chk("rst_read.strobe_gated", 32'(bus.core_data_read_en), 32'd0);
    tick();
    rst = 1'b0;
    model_reset();
    check_status("rst_read");
    wait_strobe("rst_reread", n);
    accept("rst_reread", b, 1'b0, 1'b0, 1'b0);
    pop_one("rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side buffer placed directly downstream of the UART core. It drains received bytes from the core's single-byte rx register into a FIFO of 2**FIFO_ADDR_W entries, and issues the core's one-cycle read strobe itself. It presents the buffered bytes to the CPU register file with pop/empty/level status, a sticky overrun flag and an almost-full indication. This lets software tolerate bursts without losing characters.

Parameters:
FIFO_ADDR_W, 4, log2 of FIFO depth (depth 16 by default); legal range 1..10
DATA_W, 8, byte width; fixed at 8
ALMOST_FULL_LVL, 12, level at or above which almost_full asserts; 1..2**FIFO_ADDR_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rst_soft  input  1  synchronous software reset; same effect as rst
core_rx_ready  input  1  core holds a received byte; stays high until read
core_rx_data  input  8  core received byte; valid while core_rx_ready=1
core_data_read_en  output  1  one-cycle read strobe to core (core clears rx_ready)
pop  input  1  CPU read of one byte
pop_data  output  8  byte popped; registered
pop_valid  output  1  one-cycle pulse, pop_data updated this cycle
empty  output  1  level==0
full  output  1  level==2**FIFO_ADDR_W
level  output  FIFO_ADDR_W+1  number of stored bytes
almost_full  output  1  level>=ALMOST_FULL_LVL
overrun  output  1  sticky: a byte was discarded because the FIFO was full
overrun_clr  input  1  clears overrun

Behaviour:
- rst or rst_soft (sampled at clk edge): FSM=IDLE; pointers=0; level=0; pop_data=0; pop_valid=0; core_data_read_en=0; overrun=0; empty=1; full=0; almost_full=0. Storage RAM contents are not reset.
- Ingress FSM:
  - IDLE: if core_rx_ready=1, go to READ.
  - READ (1 cycle): core_data_read_en=1. Capture core_rx_data.
    - If not full (evaluated this cycle, after any same-cycle pop): write at wr_ptr and increment wr_ptr.
    - Otherwise: discard the byte and set overrun=1.
    - Go to WAIT.
  - WAIT: stay while core_rx_ready=1; go to IDLE when core_rx_ready=0. This guarantees one strobe per byte even if the core drops ready late.
- core_data_read_en is high only in READ, never for two consecutive cycles. Minimum spacing between strobes is 3 cycles.
- Egress:
  - pop=1 with empty=0: read at rd_ptr; pop_data and pop_valid=1 register on the next edge (latency 1); rd_ptr increments.
  - pop=1 with empty=1: ignored. pop_valid=0, pop_data holds, no underflow.
- Pointers are FIFO_ADDR_W bits and wrap modulo depth. level is tracked with a counter:
  - +1 on write only
  - -1 on pop only
  - unchanged on simultaneous write and pop
- Simultaneous write and pop when full: the pop frees a slot, so the write is accepted, level stays at depth and no overrun occurs.
- Simultaneous write and pop when empty: the pop is ignored (empty at cycle start), the write lands, level becomes 1.
- empty, full and almost_full are combinational from level.
- overrun: set by a discard, cleared by overrun_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation (including in READ or WAIT): FSM returns to IDLE. A byte still pending in the core (core_rx_ready=1) is re-read after reset. A strobe is never issued in the reset cycle.

Test Plan:
- Single byte: core_rx_ready rises with 0xA5 -> core_data_read_en pulses once 1 cycle later; level=1, empty=0. pop -> next cycle pop_valid=1, pop_data=0xA5, level=0, empty=1.
- Fill/wrap: push 16 bytes 0x00..0x0F -> full=1, almost_full from 12th byte. Pop 4, push 0x10..0x13, pop all -> order 0x04..0x13, then empty=1.
- Overrun: with full=1, present 0x77 -> read strobe issued, byte discarded, overrun=1, level=16, FIFO content unchanged. overrun_clr -> overrun=0. overrun_clr in the same cycle as a new discard -> overrun stays 1.
- Simultaneous ops: full FIFO, pop in the same cycle as the READ write -> level stays 16, no overrun. Empty FIFO, pop in the same cycle as a write -> pop ignored, level=1.
- Pop when empty: pop for 3 cycles -> pop_valid=0, level=0, pop_data unchanged.
- Reset/soft reset mid-transfer: assert rst_soft during WAIT with level=5 -> level=0, empty=1, overrun=0. Core byte still pending -> read again after release, level=1.
